// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared widths, micro-address map and microword layout for the
//            microprogrammed control unit.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam int UADDR_W = 6;
  localparam int UCTRL_W = 20;
  localparam int UOP_W   = 26;
  localparam int OPC_W   = 4;

  // Microword layout: [CTRL_MSB:CTRL_LSB] control field, [NEXT_MSB:NEXT_LSB] next field
  localparam int NEXT_LSB = 0;
  localparam int NEXT_MSB = UADDR_W - 1;
  localparam int CTRL_LSB = UADDR_W;
  localparam int CTRL_MSB = UOP_W - 1;
  localparam int COND_BIT = 19;

  typedef logic [UADDR_W-1:0] uaddr_t;
  typedef logic [UCTRL_W-1:0] uctrl_t;
  typedef logic [OPC_W-1:0]   opcode_t;

  typedef struct packed {
    uctrl_t ctrl;
    uaddr_t next;
  } uword_t;

  localparam uaddr_t FETCH_ADDR    = 6'd0;
  localparam uaddr_t DECODE_ADDR   = 6'd2;
  localparam uaddr_t DISPATCH_BASE = 6'd3;
  localparam uaddr_t MAX_ADDR      = 6'd18;

  function automatic logic is_cond(input uword_t w);
    return w.ctrl[COND_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/micro_sequencer_next_addr.sv
`default_nettype none
// ============================================================================
// Module   : micro_next_addr
// Brief    : Combinational next micro-address selection (dispatch, conditional
//            branch, sequential) with out-of-range detection.
// Revision : 1.0 - initial release
// ============================================================================
module micro_next_addr
  import cpu_ctrl_pkg::*;
(
  input  logic    [UADDR_W-1:0] upc,
  input  uword_t                micro_op,
  input  logic    [OPC_W-1:0]   opcode,
  input  logic                  cond_flag,
  output logic    [UADDR_W-1:0] nxt,
  output logic                  illegal
);

  // Dispatch outranks the branch bit: the decode microword's own fields are ignored
  always_comb begin
    nxt = micro_op.next;
    if (upc == DECODE_ADDR) begin
      nxt = DISPATCH_BASE + uaddr_t'(opcode);
    end else if (is_cond(micro_op)) begin
      nxt = {micro_op.next[NEXT_MSB:NEXT_LSB+1], cond_flag};
    end
  end

  assign illegal = (nxt > MAX_ADDR);

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Brief    : Micro-PC, microinstruction register and status pulses driving the
//            microprogram ROM and the datapath control lines.
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                stall,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                cond_flag,
  input  logic [UOP_W-1:0]    micro_op,
  output logic [UADDR_W-1:0]  micro_addr,
  output logic [UCTRL_W-1:0]  ctrl,
  output logic                instr_done,
  output logic                err_illegal,
  output logic [7:0]          step_cnt
);

  logic [UADDR_W-1:0] r_upc;
  logic [UCTRL_W-1:0] r_ctrl;
  logic               r_instr_done;
  logic               r_err_illegal;
  logic [7:0]         r_step_cnt;

  logic [UADDR_W-1:0] w_nxt;
  logic               w_illegal;
  logic               w_advance;

  micro_next_addr u_next_addr (
    .upc       (r_upc),
    .micro_op  (uword_t'(micro_op)),
    .opcode    (opcode),
    .cond_flag (cond_flag),
    .nxt       (w_nxt),
    .illegal   (w_illegal)
  );

  assign w_advance = en && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upc         <= FETCH_ADDR;
      r_ctrl        <= '0;
      r_instr_done  <= 1'b0;
      r_err_illegal <= 1'b0;
      r_step_cnt    <= 8'd0;
    end else if (!en) begin
      r_ctrl        <= '0;
      r_instr_done  <= 1'b0;
      r_err_illegal <= 1'b0;
    end else if (!w_advance) begin
      // Stall keeps uPC and uIR so control lines stay asserted through the wait
      r_instr_done  <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_step_cnt <= r_step_cnt + 8'd1;
      if (w_illegal) begin
        r_upc         <= FETCH_ADDR;
        r_ctrl        <= '0;
        r_instr_done  <= 1'b0;
        r_err_illegal <= 1'b1;
      end else begin
        r_upc         <= w_nxt;
        r_ctrl        <= micro_op[CTRL_MSB:CTRL_LSB];
        r_instr_done  <= (r_upc != FETCH_ADDR) && (w_nxt == FETCH_ADDR);
        r_err_illegal <= 1'b0;
      end
    end
  end

  assign micro_addr  = r_upc;
  assign ctrl        = r_ctrl;
  assign instr_done  = r_instr_done;
  assign err_illegal = r_err_illegal;
  assign step_cnt    = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Brief    : Self-checking bench with a ROM model and an expected-state queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  typedef struct {
    logic [5:0]  upc;
    logic [19:0] ctrl;
    logic        done;
    logic        err;
    logic [7:0]  step;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic [3:0]  opcode;
  logic        cond_flag;
  logic [25:0] r_micro_op;
  logic [5:0]  w_micro_addr;
  logic [19:0] w_ctrl;
  logic        w_instr_done;
  logic        w_err_illegal;
  logic [7:0]  w_step_cnt;

  logic [25:0] rom [0:63];
  exp_t        sb_q [$];

  logic [5:0]  m_upc;
  logic [19:0] m_ctrl;
  logic        m_done;
  logic        m_err;
  logic [7:0]  m_step;

  int n_checks = 0;
  int n_fail   = 0;

  micro_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .stall       (stall),
    .opcode      (opcode),
    .cond_flag   (cond_flag),
    .micro_op    (r_micro_op),
    .micro_addr  (w_micro_addr),
    .ctrl        (w_ctrl),
    .instr_done  (w_instr_done),
    .err_illegal (w_err_illegal),
    .step_cnt    (w_step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb r_micro_op = rom[w_micro_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected next state from the current model state and inputs
  task automatic predict();
    logic [25:0] op;
    logic [5:0]  n;
    exp_t        e;
    op = rom[m_upc];
    if (m_upc == 6'd2)  n = 6'd3 + {2'b00, opcode};
    else if (op[25])    n = {op[5:1], cond_flag};
    else                n = op[5:0];
    if (!rst_n) begin
      m_upc = 6'd0; m_ctrl = 20'd0; m_done = 1'b0; m_err = 1'b0; m_step = 8'd0;
    end else if (!en) begin
      m_ctrl = 20'd0; m_done = 1'b0; m_err = 1'b0;
    end else if (stall) begin
      m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_step = m_step + 8'd1;
      if (n > 6'd18) begin
        m_upc = 6'd0; m_ctrl = 20'd0; m_done = 1'b0; m_err = 1'b1;
      end else begin
        m_done = (m_upc != 6'd0) && (n == 6'd0);
        m_err  = 1'b0;
        m_ctrl = op[25:6];
        m_upc  = n;
      end
    end
    e.upc = m_upc; e.ctrl = m_ctrl; e.done = m_done; e.err = m_err; e.step = m_step;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t got;
    predict();
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("upc",  32'(w_micro_addr),  32'(got.upc));
    check("ctrl", 32'(w_ctrl),        32'(got.ctrl));
    check("done", 32'(w_instr_done),  32'(got.done));
    check("err",  32'(w_err_illegal), 32'(got.err));
    check("step", 32'(w_step_cnt),    32'(got.step));
  endtask

  task automatic run_to_decode();
    step();
    check("at_uaddr1", 32'(w_micro_addr), 32'd1);
    step();
    check("at_uaddr2", 32'(w_micro_addr), 32'd2);
  endtask

  initial begin
    logic [19:0] held_ctrl;
    logic [7:0]  held_step;

    for (int a = 0; a < 64; a++) rom[a] = {1'b0, 13'h1ABC, 6'(a), 6'd0};
    rom[0][5:0]  = 6'd1;
    rom[1][5:0]  = 6'd2;
    rom[8]       = {1'b1, 19'h2F0F1, 6'd16};
    rom[16][5:0] = 6'd7;
    rom[17][5:0] = 6'd7;
    rom[18][5:0] = 6'd40;
    rom[5][5:0]  = 6'd4;
    rom[4][5:0]  = 6'd12;
    rom[12][5:0] = 6'd13;

    m_upc = 6'd0; m_ctrl = 20'd0; m_done = 1'b0; m_err = 1'b0; m_step = 8'd0;
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; opcode = 4'd5; cond_flag = 1'b0;
    step();
    step();
    check("rst_upc",  32'(w_micro_addr), 32'd0);
    check("rst_ctrl", 32'(w_ctrl),       32'd0);

    // Sequential fetch then dispatch opcode 5 -> 8, branch with flag 0 -> 16
    rst_n = 1'b1; en = 1'b1;
    run_to_decode();
    check("step_after_two", 32'(w_step_cnt), 32'd2);
    step();
    check("disp_op5", 32'(w_micro_addr), 32'd8);
    step();
    check("cond0", 32'(w_micro_addr), 32'd16);
    step();
    step();
    check("done_pulse", 32'(w_instr_done), 32'd1);
    check("done_upc",   32'(w_micro_addr), 32'd0);

    // Same path with flag 1 -> 17
    cond_flag = 1'b1;
    run_to_decode();
    step();
    step();
    check("cond1", 32'(w_micro_addr), 32'd17);
    step();
    step();
    check("done_pulse2", 32'(w_instr_done), 32'd1);

    // Opcode 15 dispatches to 18, then illegal next field 40
    opcode = 4'd15;
    run_to_decode();
    step();
    check("disp_op15", 32'(w_micro_addr), 32'd18);
    check("op15_noerr", 32'(w_err_illegal), 32'd0);
    step();
    check("ill_err",  32'(w_err_illegal), 32'd1);
    check("ill_upc",  32'(w_micro_addr),  32'd0);
    check("ill_ctrl", 32'(w_ctrl),        32'd0);
    check("ill_done", 32'(w_instr_done),  32'd0);
    step();
    check("ill_err_once", 32'(w_err_illegal), 32'd0);

    // Opcode 2 -> 5, stall three cycles while opcode changes, then release
    opcode = 4'd2;
    step();
    step();
    check("disp_op2", 32'(w_micro_addr), 32'd5);
    held_ctrl = w_ctrl;
    held_step = w_step_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 4'(i + 7);
      step();
      check("stall_upc",  32'(w_micro_addr), 32'd5);
      check("stall_ctrl", 32'(w_ctrl),       32'(held_ctrl));
      check("stall_step", 32'(w_step_cnt),   32'(held_step));
    end
    stall = 1'b0;
    step();
    check("stall_release", 32'(w_micro_addr), 32'd4);

    // Disable at 4: NOP issued and uPC held
    en = 1'b0;
    step();
    check("dis_ctrl", 32'(w_ctrl),       32'd0);
    check("dis_upc",  32'(w_micro_addr), 32'd4);
    en = 1'b1;
    step();
    check("resume_upc", 32'(w_micro_addr), 32'd12);

    // Reset mid-routine
    rst_n = 1'b0;
    step();
    check("midrst_upc",  32'(w_micro_addr), 32'd0);
    check("midrst_ctrl", 32'(w_ctrl),       32'd0);
    check("midrst_step", 32'(w_step_cnt),   32'd0);
    rst_n = 1'b1;

    // Randomised run long enough for step_cnt to wrap
    for (int i = 0; i < 500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      opcode    = 4'($urandom_range(0, 15));
      cond_flag = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer of the microprogrammed CPU control unit; sits directly upstream of the microprogram ROM.
- Holds the micro-PC and drives the ROM's 6-bit address.
- Takes the ROM's 26-bit microword back and computes the next micro-address: sequential field, opcode dispatch, or conditional branch.
- Latches the 20-bit control field into a microinstruction register (uIR) that drives the datapath.

Parameters:
- FETCH_ADDR, 6'd0, fetch entry; the target when next field is 0.
- DECODE_ADDR, 6'd2, micro-address whose successor is the opcode dispatch.
- DISPATCH_BASE, 6'd3, dispatch target = DISPATCH_BASE + opcode.
- MAX_ADDR, 6'd18, highest populated ROM address.
- COND_BIT, 19, index within the control field that marks a conditional-branch microword.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  run enable; 0 freezes sequencing and issues NOP.
- stall  in  1  datapath/memory wait; holds the current microstep.
- opcode  in  4  instruction-register opcode, sampled at dispatch.
- cond_flag  in  1  datapath condition (e.g. zero flag) for branch microwords.
- micro_op  in  26  ROM output: [25:6] control field, [5:0] next-address field.
- micro_addr  out  6  ROM address = uPC register.
- ctrl  out  20  registered control field (uIR).
- instr_done  out  1  one-cycle pulse when sequencing returns to FETCH_ADDR.
- err_illegal  out  1  one-cycle pulse on out-of-range next address.
- step_cnt  out  8  free-running count of advanced microsteps.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: uPC=FETCH_ADDR, ctrl=0, instr_done=0, err_illegal=0, step_cnt=0. Reset mid-microroutine wins over everything; no partial state survives.
- micro_addr is combinationally equal to uPC; the ROM read is combinational.
- Priority per edge: rst_n=0 > en=0 > stall=1 > advance.
  - en=0: uPC holds, ctrl<=0, pulses 0, step_cnt holds.
  - en=1, stall=1: uPC, ctrl and step_cnt all hold, so the control signals stay asserted through the memory wait; pulses 0.
  - Advance: ctrl<=micro_op[25:6], uPC<=nxt, step_cnt<=step_cnt+1 (8-bit wrap, 255->0).
- Latency: control word for address A appears on ctrl in the cycle after uPC=A. uPC already points to the successor of A in that cycle.
- Next-address rule, evaluated on the current uPC/micro_op; first match applies:
  1. uPC==DECODE_ADDR: nxt = DISPATCH_BASE + opcode (6-bit add; opcode 0..15 maps to 3..18).
  2. micro_op[6+COND_BIT]==1: nxt = {micro_op[5:1], cond_flag}, i.e. the next field with its LSB replaced by the flag.
  3. Otherwise: nxt = micro_op[5:0]. A next field of 0 means FETCH_ADDR.
- Range check: if the computed nxt > MAX_ADDR on an advance, uPC<=FETCH_ADDR, ctrl<=0, and err_illegal pulses for one cycle. instr_done does not pulse on this path.
- instr_done: registered; 1 for exactly the cycle after an advance where uPC!=FETCH_ADDR and the legal nxt==FETCH_ADDR.
- Resuming after en=0 or stall: the first advance uses micro_op of the held uPC, so no microstep is skipped or repeated.
- Simultaneous stall and dispatch: opcode is sampled only on the advancing edge; changes to opcode during a stall are honoured.

Decomposition:
- Shared package (cpu_ctrl_pkg), included by the ROM and the sequencer:
  - widths UADDR_W=6, UCTRL_W=20, UOP_W=26;
  - FETCH_ADDR, DECODE_ADDR, DISPATCH_BASE, MAX_ADDR constants;
  - field-slice localparams for the control and next fields.
- One sub-module is natural: micro_next_addr, purely combinational. It takes uPC, micro_op, opcode and cond_flag and produces nxt plus an illegal flag.
- The top level holds uPC, uIR, step_cnt and the pulse registers.

Test Plan:
- Reset then en=1, ROM model returning next fields 0->1, 1->2 -> micro_addr sequence 0,1,2; ctrl lags one cycle; step_cnt=2 after two advances.
- uPC=2 with opcode=4'd5 -> next micro_addr=8. Repeat with opcode=4'd15 -> 18 and no err_illegal.
- Microword with COND_BIT set and next=6'd16: cond_flag=0 -> uPC=16; cond_flag=1 -> uPC=17.
- stall high 3 cycles at uPC=5 -> micro_addr=5 and ctrl constant for 3 cycles, step_cnt frozen; release -> uPC advances to op(5).next.
- Next field 6'd40 -> uPC=0, ctrl=0, err_illegal high exactly 1 cycle, instr_done low. Normal next=0 from uPC=7 -> instr_done high 1 cycle.
- en=0 at uPC=4 -> ctrl=0 and uPC held; rst_n=0 mid-routine at uPC=12 -> next cycle uPC=0, ctrl=0, step_cnt=0.
